// File: rtl/ultra_measure_ctrl.sv
// rtl/ultra_measure_ctrl.sv - ultrasonic ranging sequencer: trigger, echo timing, cm conversion
// Optional build macro: MEAS_AVG4_EN (strobe the average of every four valid shots).
module ultra_measure_ctrl #(
    parameter int TRIG_CYCLES      = 500,
    parameter int CM_CYCLES        = 2900,
    parameter int ECHO_WAIT_CYCLES = 1_500_000,
    parameter int MAX_CM           = 400,
    parameter int HOLDOFF_CYCLES   = 3_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic [15:0] dis,
    output logic        opt,
    output logic        busy,
    output logic        timeout
);

    localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] WAIT_LAST = 32'(ECHO_WAIT_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);
    localparam logic [15:0] PRE_LAST  = 16'(CM_CYCLES - 1);
    localparam logic [15:0] CM_LIMIT  = 16'(MAX_CM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_MEAS,
        S_DONE,
        S_HOLD
    } state_t;

    state_t      state, state_nx;
    logic        echo_m, echo_s;
    logic [31:0] cnt, cnt_nx;
    logic [15:0] pre, pre_nx;
    logic [15:0] cm, cm_nx;
    logic        done_go;
    logic [15:0] done_val;
    logic        done_tmo;

`ifdef MEAS_AVG4_EN
    logic [17:0] sum;
    logic [1:0]  shots;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            pre   <= '0;
            cm    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pre   <= pre_nx;
            cm    <= cm_nx;
        end
    end

    // done_go marks the edge that enters DONE; the result is registered on that edge
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 32'd1;
        pre_nx   = pre;
        cm_nx    = cm;
        done_go  = 1'b0;
        done_val = cm;
        done_tmo = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (start) state_nx = S_TRIG;
            end
            S_TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_nx = S_WAIT;
                    cnt_nx   = '0;
                end
            end
            S_WAIT: begin
                if (echo_s) begin
                    state_nx = S_MEAS;
                    cnt_nx   = '0;
                    pre_nx   = '0;
                    cm_nx    = '0;
                end else if (cnt == WAIT_LAST) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                    done_go  = 1'b1;
                    done_val = 16'hFFFF;
                    done_tmo = 1'b1;
                end
            end
            S_MEAS: begin
                cnt_nx = '0;
                if (!echo_s) begin
                    state_nx = S_DONE;
                    done_go  = 1'b1;
                end else if (pre == PRE_LAST) begin
                    pre_nx = '0;
                    cm_nx  = cm + 16'd1;
                    if (cm + 16'd1 == CM_LIMIT) begin
                        state_nx = S_DONE;
                        done_go  = 1'b1;
                        done_val = 16'hFFFF;
                        done_tmo = 1'b1;
                    end
                end else begin
                    pre_nx = pre + 16'd1;
                end
            end
            S_DONE: begin
                cnt_nx   = '0;
                state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign trig = (state == S_TRIG);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dis     <= 16'h0000;
            opt     <= 1'b0;
            timeout <= 1'b0;
`ifdef MEAS_AVG4_EN
            sum     <= '0;
            shots   <= '0;
`endif
        end else begin
            opt     <= 1'b0;
            timeout <= 1'b0;
            if (done_go) begin
`ifdef MEAS_AVG4_EN
                // a failed shot flushes the running average and reports at once
                if (done_tmo) begin
                    dis     <= 16'hFFFF;
                    opt     <= 1'b1;
                    timeout <= 1'b1;
                    sum     <= '0;
                    shots   <= '0;
                end else if (shots == 2'd3) begin
                    dis   <= 16'((sum + {2'b00, done_val}) >> 2);
                    opt   <= 1'b1;
                    sum   <= '0;
                    shots <= '0;
                end else begin
                    sum   <= sum + {2'b00, done_val};
                    shots <= shots + 2'd1;
                end
`else
                dis     <= done_val;
                opt     <= 1'b1;
                timeout <= done_tmo;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ultra_measure_ctrl.sv
// tb/tb_ultra_measure_ctrl.sv - directed table-driven bench for ultra_measure_ctrl
module tb_ultra_measure_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        echo;
    logic        trig;
    logic [15:0] dis;
    logic        opt;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ultra_measure_ctrl #(
        .TRIG_CYCLES(4),
        .CM_CYCLES(10),
        .ECHO_WAIT_CYCLES(100),
        .MAX_CM(20),
        .HOLDOFF_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .echo(echo),
        .trig(trig),
        .dis(dis),
        .opt(opt),
        .busy(busy),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dly: cycles after trig falls until echo rises (-1 = never); at: expected DONE cycle
    typedef struct {
        int          dly;
        int          hi;
        logic [15:0] exp_dis;
        logic        exp_tmo;
        logic        exp_opt;
        int          at;
    } vec_t;

    vec_t        tbl[$];
    int          prev_done;
    bit          have_prev;
    logic [15:0] last_dis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_trig(input logic lvl, input string name);
        int n;
        n = 0;
        while (trig !== lvl && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, trig}, {31'd0, lvl});
    endtask

    task automatic run_shot(input int k, input vec_t v);
        int          wid;
        int          opts;
        int          tmos;
        int          first_i;
        logic [15:0] d_at;
        logic        t_at;
        wait_trig(1'b1, $sformatf("shot%0d_trig_rise", k));
        if (have_prev) chk($sformatf("shot%0d_spacing", k), cyc - prev_done, 52);
        chk($sformatf("shot%0d_busy", k), {31'd0, busy}, 1);
        wid = 0;
        while (trig && wid < 50) begin
            @(negedge clk);
            wid++;
        end
        chk($sformatf("shot%0d_trig_width", k), wid, 4);
        opts = 0;
        tmos = 0;
        first_i = -1;
        d_at = 16'h0;
        t_at = 1'b0;
        for (int i = 0; i <= v.at + 40; i++) begin
            if (i > 0) @(negedge clk);
            echo = (v.dly >= 0 && i >= v.dly && i < v.dly + v.hi);
            if (i == v.at) prev_done = cyc;
            if (timeout) tmos++;
            if (opt) begin
                opts++;
                if (first_i < 0) begin
                    first_i = i;
                    d_at = dis;
                    t_at = timeout;
                end
            end
        end
        echo = 1'b0;
        have_prev = 1'b1;
        chk($sformatf("shot%0d_opt_count", k), opts, v.exp_opt ? 1 : 0);
        chk($sformatf("shot%0d_timeout_count", k), tmos, v.exp_tmo ? 1 : 0);
        if (v.exp_opt) begin
            chk($sformatf("shot%0d_opt_cycle", k), first_i, v.at);
            chk($sformatf("shot%0d_dis", k), d_at, v.exp_dis);
            chk($sformatf("shot%0d_timeout_with_opt", k), {31'd0, t_at}, {31'd0, v.exp_tmo});
            last_dis = v.exp_dis;
        end else begin
            chk($sformatf("shot%0d_dis_held", k), dis, last_dis);
        end
    endtask

    initial begin
        int opts;
        int trigs;
        int first_i;
        logic [15:0] d_at;

        rst_n = 1'b0;
        start = 1'b0;
        echo = 1'b0;
        last_dis = 16'h0;
        have_prev = 1'b0;
        prev_done = 0;

`ifdef MEAS_AVG4_EN
        tbl.push_back('{30, 103, 16'd0, 1'b0, 1'b0, 136});
        tbl.push_back('{-1, 0, 16'hFFFF, 1'b1, 1'b1, 100});
        tbl.push_back('{30, 123, 16'd0, 1'b0, 1'b0, 156});
        tbl.push_back('{30, 143, 16'd0, 1'b0, 1'b0, 176});
        tbl.push_back('{30, 163, 16'd0, 1'b0, 1'b0, 196});
        tbl.push_back('{30, 103, 16'd13, 1'b0, 1'b1, 136});
        tbl.push_back('{30, 250, 16'hFFFF, 1'b1, 1'b1, 233});
`else
        tbl.push_back('{30, 123, 16'd12, 1'b0, 1'b1, 156});
        tbl.push_back('{-1, 0, 16'hFFFF, 1'b1, 1'b1, 100});
        tbl.push_back('{30, 250, 16'hFFFF, 1'b1, 1'b1, 233});
        tbl.push_back('{0, 5, 16'd0, 1'b0, 1'b1, 8});
        tbl.push_back('{10, 200, 16'd19, 1'b0, 1'b1, 213});
        tbl.push_back('{97, 41, 16'd4, 1'b0, 1'b1, 141});
        tbl.push_back('{98, 10, 16'hFFFF, 1'b1, 1'b1, 100});
`endif

        repeat (3) @(negedge clk);
        chk("rst_trig", {31'd0, trig}, 0);
        chk("rst_dis", dis, 0);
        chk("rst_opt", {31'd0, opt}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_trig", {31'd0, trig}, 0);

        start = 1'b1;
        @(negedge clk);
        chk("trig_after_start", {31'd0, trig}, 1);
        chk("busy_after_start", {31'd0, busy}, 1);

        foreach (tbl[k]) run_shot(k, tbl[k]);

        // start dropped mid-MEAS; shot ends on the cm limit, then HOLD and stay idle
        wait_trig(1'b1, "drop_trig_rise");
        wait_trig(1'b0, "drop_trig_fall");
        opts = 0;
        trigs = 0;
        first_i = -1;
        d_at = 16'h0;
        for (int i = 0; i <= 360; i++) begin
            if (i > 0) @(negedge clk);
            echo = (i >= 5 && i < 255);
            if (i == 20) start = 1'b0;
            if (i > 0 && trig) trigs++;
            if (opt) begin
                opts++;
                if (first_i < 0) begin
                    first_i = i;
                    d_at = dis;
                end
            end
            if (i == 258) chk("drop_busy_in_hold", {31'd0, busy}, 1);
            if (i == 259) chk("drop_busy_idle", {31'd0, busy}, 0);
        end
        echo = 1'b0;
        chk("drop_opt_count", opts, 1);
        chk("drop_opt_cycle", first_i, 208);
        chk("drop_dis", d_at, 16'hFFFF);
        chk("drop_no_trig", trigs, 0);

        // asynchronous reset during TRIG
        start = 1'b1;
        wait_trig(1'b1, "rtrig_trig_rise");
        #2 rst_n = 1'b0;
        #1;
        chk("rtrig_trig", {31'd0, trig}, 0);
        chk("rtrig_busy", {31'd0, busy}, 0);
        chk("rtrig_dis", dis, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // asynchronous reset during MEAS abandons the shot
        wait_trig(1'b1, "rmeas_trig_rise");
        wait_trig(1'b0, "rmeas_trig_fall");
        for (int i = 0; i <= 30; i++) begin
            if (i > 0) @(negedge clk);
            echo = (i >= 5);
        end
        chk("rmeas_busy_before", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmeas_trig", {31'd0, trig}, 0);
        chk("rmeas_dis", dis, 0);
        chk("rmeas_busy", {31'd0, busy}, 0);
        chk("rmeas_opt", {31'd0, opt}, 0);
        start = 1'b0;
        echo = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        opts = 0;
        trigs = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (opt) opts++;
            if (trig) trigs++;
        end
        chk("rmeas_no_opt", opts, 0);
        chk("rmeas_no_trig", trigs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
